// File: rtl/pwm_thres_mem.sv
// Double-buffered PWM threshold store. The host fills a shadow bank; a commit
// is published to the active bank atomically on the next PWM period boundary.
module pwm_thres_mem #(
   parameter int pwm_width = 16,
   parameter int num_pwm   = 4,
   localparam int aw       = (num_pwm > 1) ? $clog2(num_pwm) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [aw-1:0]        wr_addr,
   input  logic [pwm_width-1:0] wr_data,
   output logic                 wr_err,
   input  logic                 commit,
   output logic                 commit_pending,
   output logic                 commit_done,
   input  logic [aw-1:0]        thres_id,
   input  logic                 latch_mem,
   output logic [pwm_width-1:0] thres
);

   logic [pwm_width-1:0] shadow_q [num_pwm];
   logic [pwm_width-1:0] shadow_d [num_pwm];
   logic [pwm_width-1:0] active_q [num_pwm];
   logic [pwm_width-1:0] active_d [num_pwm];
   logic                 commit_pending_q, commit_pending_d;
   logic                 commit_done_q, commit_done_d;
   logic                 wr_err_q, wr_err_d;
   logic [pwm_width-1:0] thres_q, thres_d;

   logic xfer;
   logic addr_ok;
   logic id_ok;
   logic publish;

   always_comb begin
      xfer     = wr_valid & ~commit_pending_q;
      addr_ok  = int'(wr_addr) < num_pwm;
      id_ok    = int'(thres_id) < num_pwm;
      publish  = latch_mem & commit_pending_q;

      shadow_d = shadow_q;
      active_d = active_q;
      if (xfer && addr_ok) begin
         shadow_d[wr_addr] = wr_data;
      end
      // Shadow is frozen while pending, so copying shadow_q captures every
      // write made up to and including the commit cycle.
      if (publish) begin
         active_d = shadow_q;
      end

      wr_err_d      = xfer & ~addr_ok;
      commit_done_d = publish;

      commit_pending_d = commit_pending_q;
      if (publish) begin
         commit_pending_d = 1'b0;
      end else if (commit) begin
         commit_pending_d = 1'b1;
      end

      // Bypass on the boundary so the new period starts with the new bank.
      thres_d = '0;
      if (id_ok) begin
         thres_d = publish ? shadow_q[thres_id] : active_q[thres_id];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < num_pwm; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         commit_pending_q <= 1'b0;
         commit_done_q    <= 1'b0;
         wr_err_q         <= 1'b0;
         thres_q          <= '0;
      end else begin
         for (int i = 0; i < num_pwm; i++) begin
            shadow_q[i] <= shadow_d[i];
            active_q[i] <= active_d[i];
         end
         commit_pending_q <= commit_pending_d;
         commit_done_q    <= commit_done_d;
         wr_err_q         <= wr_err_d;
         thres_q          <= thres_d;
      end
   end

   assign wr_ready       = ~commit_pending_q;
   assign wr_err         = wr_err_q;
   assign commit_pending = commit_pending_q;
   assign commit_done    = commit_done_q;
   assign thres          = thres_q;

endmodule

// File: tb/tb_pwm_thres_mem.sv
// Bench for pwm_thres_mem: directed scenarios plus a randomized run against a
// bank-level reference model (shadow/active arrays and a pending flag).
module tb_pwm_thres_mem;
   localparam int PW = 16;
   localparam int NP = 3;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_valid = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [PW-1:0] wr_data = '0;
   logic          commit = 1'b0;
   logic [AW-1:0] thres_id = '0;
   logic          latch_mem = 1'b0;
   logic          wr_ready, wr_err, commit_pending, commit_done;
   logic [PW-1:0] thres;

   int checks = 0;
   int errors = 0;

   // reference model
   logic [PW-1:0] m_sh [NP];
   logic [PW-1:0] m_ac [NP];
   bit            m_pend;
   logic [PW-1:0] exp_thres;
   logic          exp_done, exp_err;

   pwm_thres_mem #(.pwm_width(PW), .num_pwm(NP)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_err(wr_err), .commit(commit), .commit_pending(commit_pending),
      .commit_done(commit_done), .thres_id(thres_id), .latch_mem(latch_mem), .thres(thres)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         m_sh[i] = '0;
         m_ac[i] = '0;
      end
      m_pend    = 0;
      exp_thres = '0;
      exp_done  = 0;
      exp_err   = 0;
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] a, input logic [PW-1:0] d,
                        input logic c, input logic l, input logic [AW-1:0] id);
      wr_valid = v; wr_addr = a; wr_data = d; commit = c; latch_mem = l; thres_id = id;
   endtask

   // One clock: the model digests the inputs seen at the edge, outputs are sampled 1ns later.
   task automatic tick();
      bit accepted, publish;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         accepted  = wr_valid && !m_pend;
         publish   = latch_mem && m_pend;
         exp_err   = accepted && (int'(wr_addr) >= NP);
         exp_done  = publish;
         if (int'(thres_id) >= NP) exp_thres = '0;
         else exp_thres = publish ? m_sh[thres_id] : m_ac[thres_id];
         if (publish) m_ac = m_sh;
         if (accepted && int'(wr_addr) < NP) m_sh[wr_addr] = wr_data;
         if (publish) m_pend = 0;
         else if (commit) m_pend = 1;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick(); tick();
      checks++; if (thres !== 16'h0) begin errors++; $display("FAIL reset_thres got %h exp 0000", thres); end
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", commit_pending); end
      checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", commit_done); end
      checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", wr_err); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", wr_ready); end
      rst = 1'b0;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0, 0, 0, AW'(i % 4));
         tick();
         checks++; if (thres !== 16'h0) begin errors++; $display("FAIL idle_thres id=%0d got %h exp 0000", i % 4, thres); end
         checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", wr_ready); end
      end
      $display("test_idle done");
   endtask

   task automatic test_commit_hold();
      drive(1, 2, 16'h1234, 0, 0, 2); tick();
      drive(0, 0, 0, 1, 0, 2); tick();
      checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL hold_pending got %b exp 1", commit_pending); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got %b exp 0", wr_ready); end
      drive(1, 2, 16'hBEEF, 0, 0, 2); tick();
      checks++; if (thres !== 16'h0) begin errors++; $display("FAIL hold_thres got %h exp 0000", thres); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL hold_ready2 got %b exp 0", wr_ready); end
      drive(0, 0, 0, 0, 0, 2); tick();
      checks++; if (thres !== 16'h0) begin errors++; $display("FAIL hold_thres2 got %h exp 0000", thres); end
      checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL hold_pending2 got %b exp 1", commit_pending); end
      $display("test_commit_hold done");
   endtask

   task automatic test_publish();
      drive(0, 0, 0, 0, 1, 2); tick();
      checks++; if (thres !== 16'h1234) begin errors++; $display("FAIL pub_thres got %h exp 1234", thres); end
      checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL pub_done got %b exp 1", commit_done); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL pub_ready got %b exp 1", wr_ready); end
      drive(0, 0, 0, 0, 0, 2); tick();
      checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL pub_done_once got %b exp 0", commit_done); end
      checks++; if (thres !== 16'h1234) begin errors++; $display("FAIL pub_thres_hold got %h exp 1234", thres); end
      // republish: the write attempted while frozen must not have landed
      drive(0, 0, 0, 1, 0, 2); tick();
      drive(0, 0, 0, 0, 1, 2); tick();
      checks++; if (thres !== 16'h1234) begin errors++; $display("FAIL pub_frozen got %h exp 1234", thres); end
      drive(0, 0, 0, 0, 0, 2); tick();
      $display("test_publish done");
   endtask

   task automatic test_same_cycle();
      drive(1, 0, 16'h00FF, 1, 0, 0); tick();
      checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL same_pending got %b exp 1", commit_pending); end
      checks++; if (thres !== 16'h0) begin errors++; $display("FAIL same_old got %h exp 0000", thres); end
      drive(0, 0, 0, 0, 1, 0); tick();
      checks++; if (thres !== 16'h00FF) begin errors++; $display("FAIL same_thres got %h exp 00ff", thres); end
      checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL same_done got %b exp 1", commit_done); end
      drive(0, 0, 0, 0, 0, 0); tick();
      $display("test_same_cycle done");
   endtask

   task automatic test_wr_err();
      logic [PW-1:0] want [4];
      want[0] = 16'h00FF; want[1] = 16'h0; want[2] = 16'h1234; want[3] = 16'h0;
      drive(1, 3, 16'hDEAD, 0, 0, 0); tick();
      checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b exp 1", wr_err); end
      drive(0, 0, 0, 0, 0, 0); tick();
      checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL err_once got %b exp 0", wr_err); end
      drive(0, 0, 0, 1, 0, 0); tick();
      drive(0, 0, 0, 0, 1, 0); tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, AW'(i)); tick();
         checks++; if (thres !== want[i]) begin errors++; $display("FAIL err_bank id=%0d got %h exp %h", i, thres, want[i]); end
      end
      $display("test_wr_err done");
   endtask

   task automatic test_commit_latch_same();
      drive(1, 1, 16'h5A5A, 0, 0, 1); tick();
      drive(0, 0, 0, 1, 1, 1); tick();
      checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL cl_pending got %b exp 1", commit_pending); end
      checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL cl_done got %b exp 0", commit_done); end
      checks++; if (thres !== 16'h0) begin errors++; $display("FAIL cl_thres got %h exp 0000", thres); end
      drive(0, 0, 0, 0, 0, 1); tick();
      drive(0, 0, 0, 0, 1, 1); tick();
      checks++; if (thres !== 16'h5A5A) begin errors++; $display("FAIL cl_pub got %h exp 5a5a", thres); end
      checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL cl_pub_done got %b exp 1", commit_done); end
      drive(1, 1, 16'h7777, 0, 0, 1); tick();
      drive(0, 0, 0, 1, 0, 1); tick();
      checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL rst_pending_pre got %b exp 1", commit_pending); end
      rst = 1'b1;
      #1;
      model_reset();
      checks++; if (thres !== 16'h0) begin errors++; $display("FAIL rst_thres got %h exp 0000", thres); end
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b exp 0", commit_pending); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", wr_ready); end
      checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", commit_done); end
      checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", wr_err); end
      tick();
      rst = 1'b0;
      drive(0, 0, 0, 0, 1, 1); tick();
      checks++; if (thres !== 16'h0) begin errors++; $display("FAIL rst_nopub got %h exp 0000", thres); end
      checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL rst_nodone got %b exp 0", commit_done); end
      drive(0, 0, 0, 0, 0, 2); tick();
      checks++; if (thres !== 16'h0) begin errors++; $display("FAIL rst_cleared got %h exp 0000", thres); end
      $display("test_commit_latch_same done");
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), PW'($urandom),
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
               AW'($urandom_range(0, 3)));
         if (wr_valid && wr_ready)
            $display("rand %0d: write addr=%0d data=%h", n, wr_addr, wr_data);
         tick();
         checks++; if (thres !== exp_thres) begin errors++; $display("FAIL rand_thres n=%0d got %h exp %h", n, thres, exp_thres); end
         checks++; if (commit_done !== exp_done) begin errors++; $display("FAIL rand_done n=%0d got %b exp %b", n, commit_done, exp_done); end
         checks++; if (wr_err !== exp_err) begin errors++; $display("FAIL rand_err n=%0d got %b exp %b", n, wr_err, exp_err); end
         checks++; if (commit_pending !== m_pend) begin errors++; $display("FAIL rand_pending n=%0d got %b exp %b", n, commit_pending, m_pend); end
         checks++; if (wr_ready !== !m_pend) begin errors++; $display("FAIL rand_ready n=%0d got %b exp %b", n, wr_ready, !m_pend); end
      end
      $display("test_random done");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_idle();
      test_commit_hold();
      test_publish();
      test_same_cycle();
      test_wr_err();
      test_commit_latch_same();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
